// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment driver: scans packed digit nibbles one digit at a time,
// blanks blinking digits on alternate half-periods, and registers every display output.
module seg_scan_driver #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned BLINK_DIV  = 50000000,
  localparam int unsigned IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int unsigned SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1,
  localparam int unsigned BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1
) (
  input  logic                    MCLK,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        scan_idx
);

  logic [SCAN_W-1:0]     scan_cnt_q;
  logic [BLINK_W-1:0]    blink_cnt_q;
  logic                  blink_phase_q;
  logic                  scan_tick;
  logic                  blink_tick;
  logic [3:0]            cur_digit;
  logic [6:0]            pattern;
  logic                  blanked;
  logic [6:0]            seg_d;
  logic                  seg_dp_d;
  logic [NUM_DIGITS-1:0] an_d;

  assign scan_tick  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
  assign blink_tick = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));

  always_comb begin
    cur_digit = digits[4*int'(scan_idx) +: 4];
    blanked   = blink_phase_q & blink_mask[scan_idx];
    // Active-high g..a; inverted below for the active-low cathodes.
    case (cur_digit)
      4'h0:    pattern = 7'h3F;
      4'h1:    pattern = 7'h06;
      4'h2:    pattern = 7'h5B;
      4'h3:    pattern = 7'h4F;
      4'h4:    pattern = 7'h66;
      4'h5:    pattern = 7'h6D;
      4'h6:    pattern = 7'h7D;
      4'h7:    pattern = 7'h07;
      4'h8:    pattern = 7'h7F;
      4'h9:    pattern = 7'h6F;
      4'hA:    pattern = 7'h77;
      4'hB:    pattern = 7'h7C;
      4'hC:    pattern = 7'h39;
      4'hD:    pattern = 7'h5E;
      4'hE:    pattern = 7'h79;
      default: pattern = 7'h00;
    endcase
    seg_d    = blanked ? 7'h7F : ~pattern;
    seg_dp_d = blanked ? 1'b1 : ~dp[scan_idx];
    an_d     = en ? ~(NUM_DIGITS'(1) << scan_idx) : {NUM_DIGITS{1'b1}};
  end

  always_ff @(posedge MCLK) begin
    if (rst) begin
      scan_cnt_q    <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      scan_idx      <= '0;
      seg           <= 7'h7F;
      seg_dp        <= 1'b1;
      an            <= {NUM_DIGITS{1'b1}};
    end else begin
      scan_cnt_q <= scan_tick ? '0 : scan_cnt_q + 1'b1;
      if (scan_tick) begin
        scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
      end
      blink_cnt_q <= blink_tick ? '0 : blink_cnt_q + 1'b1;
      if (blink_tick) begin
        blink_phase_q <= ~blink_phase_q;
      end
      seg    <= seg_d;
      seg_dp <= seg_dp_d;
      an     <= an_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4, BLINK_DIV=16; n counts edges since reset
// release, so outputs after edge n reflect idx ((n-1)/4)%6 and blink phase ((n-1)/16)%2.
module tb_seg_scan_driver;

  logic        MCLK = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [23:0] digits = 24'h0;
  logic [5:0]  blink_mask = 6'h0;
  logic [5:0]  dp = 6'h0;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [5:0]  an;
  logic [2:0]  scan_idx;

  int n_tests = 0;
  int n_fail  = 0;
  int n       = 0;

  seg_scan_driver #(
    .NUM_DIGITS(6),
    .SCAN_DIV  (4),
    .BLINK_DIV (16)
  ) dut (
    .MCLK      (MCLK),
    .rst       (rst),
    .en        (en),
    .digits    (digits),
    .blink_mask(blink_mask),
    .dp        (dp),
    .seg       (seg),
    .seg_dp    (seg_dp),
    .an        (an),
    .scan_idx  (scan_idx)
  );

  always #5 MCLK = ~MCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (n=%0d): got %h, expected %h", tag, n, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
    n++;
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  task automatic do_reset(input bit verify);
    rst = 1'b1;
    repeat (3) begin
      tick();
      if (verify) begin
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", seg_dp, 1'b1);
        check("rst_an", an, 6'h3F);
        check("rst_idx", scan_idx, 3'd0);
      end
    end
    rst = 1'b0;
    n   = 0;
  endtask

  initial begin
    // 1. Reset with arbitrary inputs
    digits = 24'h8A0F31; dp = 6'h3F; blink_mask = 6'h15; en = 1'b1;
    do_reset(1'b1);

    // 2. Scan order and decode
    digits = 24'h123456; dp = 6'h00; blink_mask = 6'h00;
    tick();
    check("scan_an0", an, 6'h3E);
    check("scan_seg6", seg, 7'h02);
    check("scan_dp0", seg_dp, 1'b1);
    run_to(3); check("scan_idx_hold", scan_idx, 3'd0);
    run_to(4); check("scan_an0_held", an, 6'h3E);
    check("scan_idx_adv", scan_idx, 3'd1);
    run_to(5);  check("scan_an1", an, 6'h3D); check("scan_seg5", seg, 7'h12);
    run_to(9);  check("scan_an2", an, 6'h3B); check("scan_seg4", seg, 7'h19);
    run_to(13); check("scan_an3", an, 6'h37); check("scan_seg3", seg, 7'h30);
    run_to(17); check("scan_an4", an, 6'h2F); check("scan_seg2", seg, 7'h24);
    run_to(21); check("scan_an5", an, 6'h1F); check("scan_seg1", seg, 7'h79);
    run_to(24); check("scan_an5_held", an, 6'h1F);
    check("scan_idx_wrap", scan_idx, 3'd0);
    run_to(25); check("scan_an_wrap", an, 6'h3E);

    // 3. Blink on digit 0 with its decimal point lit
    do_reset(1'b0);
    blink_mask = 6'b000001; dp = 6'b000001;
    tick();
    check("blk_seg_on", seg, 7'h02); check("blk_dp_on", seg_dp, 1'b0);
    run_to(25);
    check("blk_an", an, 6'h3E);
    check("blk_seg_off", seg, 7'h7F); check("blk_dp_off", seg_dp, 1'b1);
    run_to(28); check("blk_seg_off_end", seg, 7'h7F);
    run_to(29); check("blk_other_an", an, 6'h3D); check("blk_other_seg", seg, 7'h12);
    run_to(49); check("blk_seg_off2", seg, 7'h7F);
    run_to(73); check("blk_an_again", an, 6'h3E); check("blk_seg_on2", seg, 7'h02);
    check("blk_dp_on2", seg_dp, 1'b0);

    // 4. Blank nibble, decimal point, mid-dwell changes and letter decode
    do_reset(1'b0);
    digits = 24'h123F56; dp = 6'b000100; blink_mask = 6'h00;
    run_to(5); check("bl_dp_other", seg_dp, 1'b1);
    run_to(9); check("bl_an", an, 6'h3B);
    check("bl_seg", seg, 7'h7F); check("bl_dp", seg_dp, 1'b0);
    run_to(10);
    digits = 24'h123A56; tick(); check("dec_A", seg, 7'h08);
    digits = 24'h123B56; tick(); check("dec_b", seg, 7'h03);
    digits = 24'hCCCCCC; tick(); check("dec_C", seg, 7'h46);
    digits = 24'hDDDDDD; tick(); check("dec_d", seg, 7'h21);
    digits = 24'hEEEEEE; tick(); check("dec_E", seg, 7'h06);
    digits = 24'h777777; tick(); check("dec_7", seg, 7'h78);
    digits = 24'h999999; tick(); check("dec_9", seg, 7'h10);
    digits = 24'h000000; tick(); check("dec_0", seg, 7'h40);
    digits = 24'h888888; tick(); check("dec_8", seg, 7'h00);

    // 5. Reset pulse while scan_idx=3 and blink phase=1
    do_reset(1'b0);
    digits = 24'h123456; dp = 6'h00; blink_mask = 6'h3F;
    run_to(61);
    check("mr_idx_pre", scan_idx, 3'd3);
    check("mr_seg_pre", seg, 7'h7F);
    rst = 1'b1;
    tick();
    check("mr_an", an, 6'h3F); check("mr_idx", scan_idx, 3'd0); check("mr_seg", seg, 7'h7F);
    rst = 1'b0; n = 0;
    tick();
    check("mr_an_post", an, 6'h3E); check("mr_seg_post", seg, 7'h02);

    // 6. Enable gating with free-running scan
    do_reset(1'b0);
    blink_mask = 6'h00;
    run_to(2);
    en = 1'b0;
    run_to(3);  check("en_off_an", an, 6'h3F);
    run_to(12); check("en_off_an_end", an, 6'h3F); check("en_off_idx", scan_idx, 3'd3);
    en = 1'b1;
    run_to(13); check("en_resume_an", an, 6'h37); check("en_resume_seg", seg, 7'h30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
